// File: rtl/popcount30_pkg.sv
// Shared constants and types for the popcount30 family: frame length,
// count width, transmitter FSM states and frame-generation modes.
package popcount30_pkg;

  localparam int N_BITS = 30;
  localparam int CNT_W  = 5;

  // Largest count representable in a 30-beat frame; larger requests saturate.
  localparam logic [CNT_W-1:0] K_MAX = 5'd30;

  // Width of the Bresenham accumulator: acc + k tops out at 29 + 30 = 59.
  localparam int ACC_W = 6;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  typedef enum logic {
    MODE_THERMO,
    MODE_SPREAD
  } tx_mode_t;

endpackage

// File: rtl/popcount30_spread_step.sv
// One Bresenham step for spreading k ones evenly over a 30-beat frame.
// Purely combinational so a receiver-side checker can reuse it.
module popcount30_spread_step
  import popcount30_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [CNT_W-1:0] k,
  output logic             bit_o,
  output logic [ACC_W-1:0] acc_next
);

  localparam logic [ACC_W-1:0] FRAME_LEN = 6'd30;

  logic [ACC_W-1:0] sum;

  always_comb begin
    sum      = acc + {1'b0, k};
    bit_o    = (sum >= FRAME_LEN);
    acc_next = bit_o ? (sum - FRAME_LEN) : sum;
  end

endmodule

// File: rtl/popcount30_unary_tx.sv
// Count-to-frame expander: accepts a population count and streams a 30-bit
// frame with exactly that many ones, thermometer or evenly spread.
module popcount30_unary_tx
  import popcount30_pkg::*;
#(
  parameter int N_BITS = 30,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_count,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic [N_BITS-1:0] frame,
  output logic              frame_valid,
  output logic              sat
);

  if (N_BITS != 30 || CNT_W != 5) begin : g_bad_param
    $error("popcount30_unary_tx supports only N_BITS=30, CNT_W=5");
  end

  localparam logic [4:0] LAST_IDX = 5'd29;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > K_MAX) ? K_MAX : c;
  endfunction

  tx_state_t         state_q, state_d;
  tx_mode_t          mode_q, mode_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [4:0]        idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [N_BITS-1:0] cap_q, cap_d;
  logic [N_BITS-1:0] frame_q, frame_d;
  logic              frame_valid_q, frame_valid_d;
  logic              sat_q, sat_d;

  logic              accept;
  logic              beat_hs;
  logic              last_beat;
  logic              last_hs;
  logic              spread_bit;
  logic [ACC_W-1:0]  spread_acc_next;
  logic              thermo_bit;

  popcount30_spread_step u_step (
    .acc      (acc_q),
    .k        (k_q),
    .bit_o    (spread_bit),
    .acc_next (spread_acc_next)
  );

  assign thermo_bit = (idx_q < k_q);
  assign last_beat  = (idx_q == LAST_IDX);
  assign beat_hs    = out_valid & out_ready;
  assign last_hs    = beat_hs & last_beat;
  assign accept     = in_valid & in_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a count taken on the final beat chains without a bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (last_hs) state_d = accept ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, combinational from registered state so they hold during stalls
  always_comb begin
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SEND: begin
        out_valid = 1'b1;
        out_bit   = (mode_q == MODE_SPREAD) ? spread_bit : thermo_bit;
        out_last  = last_beat;
        in_ready  = last_beat & out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    mode_d        = mode_q;
    k_d           = k_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    cap_d         = cap_q;
    frame_d       = frame_q;
    frame_valid_d = last_hs;
    sat_d         = accept & (in_count > K_MAX);

    if (beat_hs) begin
      cap_d = {out_bit, cap_q[N_BITS-1:1]};
      idx_d = idx_q + 5'd1;
      acc_d = spread_acc_next;
    end
    if (last_hs) begin
      frame_d = {out_bit, cap_q[N_BITS-1:1]};
    end
    if (accept) begin
      mode_d = tx_mode_t'(in_mode);
      k_d    = sat_count(in_count);
      idx_d  = 5'd0;
      acc_d  = '0;
    end
  end

  // Control and visible outputs reset; the capture datapath is fully refilled each frame
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= 5'd0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      sat_q         <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    k_q    <= k_d;
    acc_q  <= acc_d;
    cap_q  <= cap_d;
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign sat         = sat_q;

endmodule
